rob_submit_arbiter: RTL and testbench
=====================================

Name: rob_submit_arbiter

Overview:
- Sits between the execution units (reservation-station ALU path, load/store buffer) and the reorder buffer's result-submit port.
- Buffers completed results per source in small FIFOs.
- Round-robin arbitrates one result per cycle onto a single submit channel, with ready/valid backpressure on both sides.
- Flushes all buffered results on branch mispredict.

Parameters:
- TAG_W, 4, ROB tag width; tag 0 means "none".
- DATA_W, 32, result value width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global enable; low freezes all state
- flush_in  input  1  mispredict clear (predict_fail)
- rs_valid_in  input  1  RS result valid
- rs_tag_in  input  TAG_W  RS result ROB tag
- rs_val_in  input  DATA_W  RS result value
- rs_ready_out  output  1  RS FIFO can accept
- lsb_valid_in  input  1  LSB result valid
- lsb_tag_in  input  TAG_W  LSB result ROB tag
- lsb_val_in  input  DATA_W  LSB result value
- lsb_ready_out  output  1  LSB FIFO can accept
- sub_valid_out  output  1  submit to ROB valid
- sub_tag_out  output  TAG_W  granted tag
- sub_val_out  output  DATA_W  granted value
- sub_src_out  output  1  0 = RS, 1 = LSB
- sub_ready_in  input  1  ROB accepts submit

Behaviour:
- Reset: asynchronous on rst_n_in low.
  - Both FIFOs empty; prio register = RS.
  - All outputs 0, including both ready outputs while reset is asserted.
- Ready signals:
  - x_ready_out = rdy_in && !fifo_x_full.
  - Not pop-aware: a full FIFO refuses input even in a cycle it pops.
- Enqueue: on a clock edge with rdy_in && !flush_in && x_valid_in && x_ready_out.
  - Tag 0: accepted (handshake completes) but discarded, not stored.
- Output is combinational from the FIFO heads plus the prio register:
  - Both FIFOs non-empty: grant the source named by prio.
  - One FIFO non-empty: grant that source.
  - sub_valid_out = rdy_in && any FIFO non-empty.
  - No grant: tag, value and src outputs are 0.
- Pop: on an edge with rdy_in && !flush_in && sub_valid_out && sub_ready_in.
  - The granted FIFO pops.
  - prio becomes the other source.
  - prio is unchanged if nothing pops.
- Latency: input accepted at edge N appears on sub_* after edge N (one cycle), provided it wins arbitration.
- Same-cycle enqueue and pop on one FIFO: both take effect; occupancy unchanged.
- Per-source order: FIFO order is preserved; no ordering between sources.
- Pointer wrap: FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- flush_in && rdy_in at an edge:
  - Both FIFOs emptied; prio = RS.
  - Same-cycle inputs and pop are discarded; flush has priority over everything.
- rdy_in low: no state change; ready and valid outputs are 0.
- Reset mid-operation: immediate clear, regardless of rdy_in or flush_in.

Optional Feature:
- Macro: ROB_SUBMIT_ARB_BYPASS_EN.
- Defined:
  - When the granted-candidate FIFO of a source is empty and its input is valid with nonzero tag, the input is forwarded onto sub_* in the same cycle (zero latency).
  - The input is enqueued only if the ROB does not accept it.
  - Arbitration treats a bypass-eligible input as a non-empty FIFO.
- Undefined: one-cycle minimum latency, as above.

Decomposition:
- Shared package rob_pkg:
  - TAG_W, DATA_W
  - ROB_TAG_NONE = 0
  - SRC_RS = 0, SRC_LSB = 1
  - result struct/typedef {tag, val}
- Natural sub-module: result_fifo.
  - Synchronous FIFO with full/empty/flush.
  - Instantiated twice.

Test Plan:
- Reset then RS result (tag 3, val 0x11) with sub_ready_in=1 -> next cycle sub_valid_out=1, tag 3, val 0x11, src 0; popped after that edge.
- RS (tag 1) and LSB (tag 2) enqueued in the same cycle, ROB ready -> submits tag 1 (RS) then tag 2 (LSB); with continuous supply from both sources, grants alternate RS, LSB, RS.
- sub_ready_in=0, three RS results (tags 4, 5, 6) offered, depth 2 -> tags 4 and 5 accepted, rs_ready_out=0 for tag 6; release -> 4, 5 submitted in order, then 6 accepted.
- FIFOs holding 2 entries, flush_in=1 with rs_valid_in tag 7 -> all FIFOs empty, sub_valid_out=0 next cycle, tag 7 lost, prio=RS.
- rdy_in=0 for 3 cycles with pending LSB tag 9 -> outputs frozen or 0, no pop; rdy_in=1 -> tag 9 submitted.
- Input with tag 0 -> handshake completes, nothing submitted. With bypass enabled, empty FIFO and RS tag 8 -> sub_valid_out=1 in the same cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the ROB result-submit arbiter: widths, source
// encodings and the buffered result record.
package rob_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    // Tag value meaning "no ROB entry"; such results are dropped on entry.
    localparam logic [TAG_W-1:0] ROB_TAG_NONE = '0;

    // Source encodings used on sub_src_out and in the priority register.
    localparam logic SRC_RS  = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO of result records with full/empty status, a global
// enable that freezes all state, and a flush that empties it in one edge.
// Flush wins over push and pop. Pointers wrap modulo DEPTH.
module result_fifo
    import rob_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_en,
    input  logic    i_flush,
    input  logic    i_push,
    input  result_t i_din,
    input  logic    i_pop,
    output result_t o_dout,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    result_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign w_do_push = i_en && !i_flush && i_push && !o_full;
    assign w_do_pop  = i_en && !i_flush && i_pop  && !o_empty;

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
                else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
            end
        end
    end

    // Payload storage; contents are only meaningful behind the occupancy count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/rob_submit_arbiter.sv
// Buffers completed results from the RS and LSB paths and round-robins them
// one per cycle onto the ROB submit channel. A mispredict flush drops all
// buffered results and returns priority to RS.
// Optional build macro: ROB_SUBMIT_ARB_BYPASS_EN forwards a valid input from
// an empty source straight to the submit channel in the same cycle.
module rob_submit_arbiter
    import rob_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              rs_valid_in,
    input  logic [TAG_W-1:0]  rs_tag_in,
    input  logic [DATA_W-1:0] rs_val_in,
    output logic              rs_ready_out,
    input  logic              lsb_valid_in,
    input  logic [TAG_W-1:0]  lsb_tag_in,
    input  logic [DATA_W-1:0] lsb_val_in,
    output logic              lsb_ready_out,
    output logic              sub_valid_out,
    output logic [TAG_W-1:0]  sub_tag_out,
    output logic [DATA_W-1:0] sub_val_out,
    output logic              sub_src_out,
    input  logic              sub_ready_in
);

    logic    r_prio;

    result_t w_rs_head;
    result_t w_lsb_head;
    logic    w_rs_full;
    logic    w_rs_empty;
    logic    w_lsb_full;
    logic    w_lsb_empty;

    logic    w_rs_byp;
    logic    w_lsb_byp;
    logic    w_rs_cand;
    logic    w_lsb_cand;
    result_t w_rs_eff;
    result_t w_lsb_eff;

    logic    w_any;
    logic    w_grant_src;
    result_t w_grant;
    logic    w_fire;
    logic    w_rs_pop;
    logic    w_lsb_pop;
    logic    w_rs_push;
    logic    w_lsb_push;

    // Ready is not pop-aware: a full FIFO refuses input even while it drains.
    assign rs_ready_out  = rst_n_in && rdy_in && !w_rs_full;
    assign lsb_ready_out = rst_n_in && rdy_in && !w_lsb_full;

`ifdef ROB_SUBMIT_ARB_BYPASS_EN
    // An input arriving at an empty source competes as if it were the head.
    assign w_rs_byp  = w_rs_empty  && rs_valid_in  && (rs_tag_in  != ROB_TAG_NONE);
    assign w_lsb_byp = w_lsb_empty && lsb_valid_in && (lsb_tag_in != ROB_TAG_NONE);
`else
    assign w_rs_byp  = 1'b0;
    assign w_lsb_byp = 1'b0;
`endif

    assign w_rs_cand  = !w_rs_empty  || w_rs_byp;
    assign w_lsb_cand = !w_lsb_empty || w_lsb_byp;
    assign w_rs_eff   = w_rs_byp  ? '{tag: rs_tag_in,  val: rs_val_in}  : w_rs_head;
    assign w_lsb_eff  = w_lsb_byp ? '{tag: lsb_tag_in, val: lsb_val_in} : w_lsb_head;
    assign w_any      = w_rs_cand || w_lsb_cand;

    // Grant selection: priority register breaks ties, otherwise the lone candidate.
    always_comb begin
        w_grant_src = SRC_RS;
        if (w_rs_cand && w_lsb_cand) w_grant_src = r_prio;
        else if (w_lsb_cand)         w_grant_src = SRC_LSB;
        w_grant = (w_grant_src == SRC_LSB) ? w_lsb_eff : w_rs_eff;
    end

    // Submit channel drives zeros whenever nothing is offered.
    always_comb begin
        sub_valid_out = rst_n_in && rdy_in && w_any;
        sub_tag_out   = '0;
        sub_val_out   = '0;
        sub_src_out   = SRC_RS;
        if (sub_valid_out) begin
            sub_tag_out = w_grant.tag;
            sub_val_out = w_grant.val;
            sub_src_out = w_grant_src;
        end
    end

    assign w_fire    = rdy_in && !flush_in && sub_valid_out && sub_ready_in;
    assign w_rs_pop  = w_fire && (w_grant_src == SRC_RS);
    assign w_lsb_pop = w_fire && (w_grant_src == SRC_LSB);

    // Tag-none results complete the handshake but are never stored; a bypassed
    // result the ROB has already taken is not stored either.
    assign w_rs_push  = rs_valid_in  && rs_ready_out  && (rs_tag_in  != ROB_TAG_NONE)
                        && !(w_rs_byp  && w_rs_pop);
    assign w_lsb_push = lsb_valid_in && lsb_ready_out && (lsb_tag_in != ROB_TAG_NONE)
                        && !(w_lsb_byp && w_lsb_pop);

    // Round-robin pointer: after each accepted submit the other source leads.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_prio <= SRC_RS;
        end else if (rdy_in) begin
            if (flush_in)    r_prio <= SRC_RS;
            else if (w_fire) r_prio <= ~w_grant_src;
        end
    end

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_rs_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (rdy_in),
        .i_flush (flush_in),
        .i_push  (w_rs_push),
        .i_din   ('{tag: rs_tag_in, val: rs_val_in}),
        .i_pop   (w_rs_pop && !w_rs_byp),
        .o_dout  (w_rs_head),
        .o_full  (w_rs_full),
        .o_empty (w_rs_empty)
    );

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (rdy_in),
        .i_flush (flush_in),
        .i_push  (w_lsb_push),
        .i_din   ('{tag: lsb_tag_in, val: lsb_val_in}),
        .i_pop   (w_lsb_pop && !w_lsb_byp),
        .o_dout  (w_lsb_head),
        .o_full  (w_lsb_full),
        .o_empty (w_lsb_empty)
    );

endmodule

// File: tb/tb_rob_submit_arbiter.sv
// Directed bench for rob_submit_arbiter: expected submits are queued by the
// stimulus and checked by a monitor on every accepted submit handshake.
module tb_rob_submit_arbiter;
  import rob_pkg::*;

  localparam int REC_W = 1 + TAG_W + DATA_W;

  logic              clk_in;
  logic              rst_n_in;
  logic              rdy_in;
  logic              flush_in;
  logic              rs_valid_in;
  logic [TAG_W-1:0]  rs_tag_in;
  logic [DATA_W-1:0] rs_val_in;
  logic              rs_ready_out;
  logic              lsb_valid_in;
  logic [TAG_W-1:0]  lsb_tag_in;
  logic [DATA_W-1:0] lsb_val_in;
  logic              lsb_ready_out;
  logic              sub_valid_out;
  logic [TAG_W-1:0]  sub_tag_out;
  logic [DATA_W-1:0] sub_val_out;
  logic              sub_src_out;
  logic              sub_ready_in;

  logic [REC_W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  rob_submit_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .rs_valid_in   (rs_valid_in),
    .rs_tag_in     (rs_tag_in),
    .rs_val_in     (rs_val_in),
    .rs_ready_out  (rs_ready_out),
    .lsb_valid_in  (lsb_valid_in),
    .lsb_tag_in    (lsb_tag_in),
    .lsb_val_in    (lsb_val_in),
    .lsb_ready_out (lsb_ready_out),
    .sub_valid_out (sub_valid_out),
    .sub_tag_out   (sub_tag_out),
    .sub_val_out   (sub_val_out),
    .sub_src_out   (sub_src_out),
    .sub_ready_in  (sub_ready_in)
  );

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  function automatic logic [REC_W-1:0] rec(input logic src, input logic [TAG_W-1:0] tag,
                                           input logic [DATA_W-1:0] val);
    return {src, tag, val};
  endfunction

  task automatic drive_rs(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    rs_valid_in = v; rs_tag_in = t; rs_val_in = d;
  endtask

  task automatic drive_lsb(input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    lsb_valid_in = v; lsb_tag_in = t; lsb_val_in = d;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    cyc(1);
    rst_n_in = 1'b1;
    #1;
  endtask

  // scoreboard monitor: every accepted submit must match the queue head
  always @(negedge clk_in) begin
    if (rst_n_in && rdy_in && !flush_in && sub_ready_in && sub_valid_out) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_submit: got src=%0d tag=%0h val=%0h expected none",
                 sub_src_out, sub_tag_out, sub_val_out);
      end else begin
        check("submit", 64'(rec(sub_src_out, sub_tag_out, sub_val_out)), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int accepted;
    n_vec = 0;
    n_err = 0;
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; sub_ready_in = 1'b0;
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);

    // reset state while reset asserted
    #2;
    check("reset_rs_ready", 64'(rs_ready_out), 64'd0);
    check("reset_lsb_ready", 64'(lsb_ready_out), 64'd0);
    check("reset_sub_valid", 64'(sub_valid_out), 64'd0);
    check("reset_sub_tag", 64'(sub_tag_out), 64'd0);
    cyc(1);
    rst_n_in = 1'b1;
    #1;
    check("post_reset_rs_ready", 64'(rs_ready_out), 64'd1);

    // single RS result, one-cycle latency, popped after the next edge
    sub_ready_in = 1'b1;
    drive_rs(1'b1, 4'd3, 32'h11);
    exp_q.push_back(rec(SRC_RS, 4'd3, 32'h11));
    cyc(1);
    drive_rs(1'b0, '0, '0);
    #1;
    check("t1_valid", 64'(sub_valid_out), 64'd1);
    check("t1_tag", 64'(sub_tag_out), 64'd3);
    cyc(1);
    check("t1_drained", 64'(sub_valid_out), 64'd0);

    // both sources, alternation RS, LSB, RS, LSB from a fresh reset
    do_reset();
    exp_q.push_back(rec(SRC_RS,  4'd1, 32'hA1));
    exp_q.push_back(rec(SRC_LSB, 4'd2, 32'hB2));
    exp_q.push_back(rec(SRC_RS,  4'd3, 32'hA3));
    exp_q.push_back(rec(SRC_LSB, 4'd4, 32'hB4));
    drive_rs(1'b1, 4'd1, 32'hA1);
    drive_lsb(1'b1, 4'd2, 32'hB2);
    cyc(1);
    drive_rs(1'b1, 4'd3, 32'hA3);
    drive_lsb(1'b1, 4'd4, 32'hB4);
    check("t2_rs_ready", 64'(rs_ready_out), 64'd1);
    check("t2_lsb_ready", 64'(lsb_ready_out), 64'd1);
    cyc(1);
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);
    cyc(3);
    check("t2_drained", 64'(sub_valid_out), 64'd0);

    // backpressure: depth 2 fills, third RS result waits for room
    sub_ready_in = 1'b0;
    exp_q.push_back(rec(SRC_RS, 4'd4, 32'hC4));
    exp_q.push_back(rec(SRC_RS, 4'd5, 32'hC5));
    exp_q.push_back(rec(SRC_RS, 4'd6, 32'hC6));
    drive_rs(1'b1, 4'd4, 32'hC4);
    #1;
    check("t3_ready_4", 64'(rs_ready_out), 64'd1);
    cyc(1);
    drive_rs(1'b1, 4'd5, 32'hC5);
    check("t3_ready_5", 64'(rs_ready_out), 64'd1);
    cyc(1);
    drive_rs(1'b1, 4'd6, 32'hC6);
    check("t3_ready_6", 64'(rs_ready_out), 64'd0);
    check("t3_head_tag", 64'(sub_tag_out), 64'd4);
    cyc(2);
    check("t3_still_full", 64'(rs_ready_out), 64'd0);
    sub_ready_in = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (rs_ready_out) begin
        accepted = 1;
        cyc(1);
        break;
      end
      cyc(1);
    end
    drive_rs(1'b0, '0, '0);
    check("t3_tag6_accepted", 64'(accepted), 64'd1);
    cyc(2);
    check("t3_drained", 64'(sub_valid_out), 64'd0);

    // flush with two buffered entries and a same-cycle input
    sub_ready_in = 1'b0;
    drive_rs(1'b1, 4'd10, 32'hDA);
    drive_lsb(1'b1, 4'd11, 32'hDB);
    cyc(1);
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);
    check("t4_pre_valid", 64'(sub_valid_out), 64'd1);
    flush_in = 1'b1;
    sub_ready_in = 1'b1;
    drive_rs(1'b1, 4'd7, 32'hD7);
    cyc(1);
    flush_in = 1'b0;
    sub_ready_in = 1'b0;
    drive_rs(1'b0, '0, '0);
    #1;
    check("t4_flush_valid", 64'(sub_valid_out), 64'd0);
    check("t4_flush_rs_ready", 64'(rs_ready_out), 64'd1);
    check("t4_flush_lsb_ready", 64'(lsb_ready_out), 64'd1);
    // priority must be back on RS after the flush
    drive_rs(1'b1, 4'd12, 32'hE2);
    drive_lsb(1'b1, 4'd13, 32'hE3);
    cyc(1);
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);
    check("t4_prio_src", 64'(sub_src_out), 64'(SRC_RS));
    check("t4_prio_tag", 64'(sub_tag_out), 64'd12);
    exp_q.push_back(rec(SRC_RS,  4'd12, 32'hE2));
    exp_q.push_back(rec(SRC_LSB, 4'd13, 32'hE3));
    sub_ready_in = 1'b1;
    cyc(3);
    check("t4_drained", 64'(sub_valid_out), 64'd0);

    // global enable low freezes everything
    sub_ready_in = 1'b0;
    drive_lsb(1'b1, 4'd9, 32'h99);
    cyc(1);
    drive_lsb(1'b0, '0, '0);
    rdy_in = 1'b0;
    sub_ready_in = 1'b1;
    drive_rs(1'b1, 4'd14, 32'h9E);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_frozen_valid", 64'(sub_valid_out), 64'd0);
      check("t5_frozen_rs_ready", 64'(rs_ready_out), 64'd0);
      check("t5_frozen_tag", 64'(sub_tag_out), 64'd0);
      cyc(1);
    end
    drive_rs(1'b0, '0, '0);
    exp_q.push_back(rec(SRC_LSB, 4'd9, 32'h99));
    rdy_in = 1'b1;
    cyc(2);
    check("t5_drained", 64'(sub_valid_out), 64'd0);

    // tag none: handshake completes, nothing submitted
    sub_ready_in = 1'b1;
    drive_rs(1'b1, 4'd0, 32'h55);
    #1;
    check("t6_tag0_ready", 64'(rs_ready_out), 64'd1);
    check("t6_tag0_no_valid", 64'(sub_valid_out), 64'd0);
    cyc(1);
    drive_rs(1'b0, '0, '0);
    #1;
    check("t6_tag0_dropped", 64'(sub_valid_out), 64'd0);

`ifdef ROB_SUBMIT_ARB_BYPASS_EN
    // zero-latency forward from an empty source
    exp_q.push_back(rec(SRC_RS, 4'd8, 32'h88));
    drive_rs(1'b1, 4'd8, 32'h88);
    #1;
    check("t7_bypass_valid", 64'(sub_valid_out), 64'd1);
    check("t7_bypass_tag", 64'(sub_tag_out), 64'd8);
    cyc(1);
    drive_rs(1'b0, '0, '0);
    #1;
    check("t7_bypass_not_stored", 64'(sub_valid_out), 64'd0);
`endif

    // asynchronous reset in the middle of a cycle with a pending entry
    sub_ready_in = 1'b0;
    drive_lsb(1'b1, 4'd15, 32'hFF);
    cyc(1);
    drive_lsb(1'b0, '0, '0);
    check("t8_pending", 64'(sub_valid_out), 64'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("t8_async_valid", 64'(sub_valid_out), 64'd0);
    check("t8_async_lsb_ready", 64'(lsb_ready_out), 64'd0);
    cyc(1);
    rst_n_in = 1'b1;
    #1;
    check("t8_cleared", 64'(sub_valid_out), 64'd0);
    check("t8_ready_back", 64'(lsb_ready_out), 64'd1);

    // everything expected must have been submitted
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
